cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
// - Bit-serial accumulator CPU. Instructions come from an external SPI ROM; data lives in an external SPI SRAM.
// - The ROM is read as one continuous sequential stream. hold_rom_n pauses the stream while an instruction
//   executes. The CPU issues a new READ only after reset or a taken jump.
// - Both memories are clocked from clk (SCK = clk). The CPU drives mosi on each posedge and samples miso on each posedge.
// PARAMETERS
// - none (address width fixed at 24 bits, data byte 8 bits, SPI READ=0x03, WRITE=0x02)
// PORTS
// - clk         in  1  system clock, also memory SCK
// - rst         in  1  synchronous, active-high reset
// - miso_rom    in  1  ROM serial data out
// - miso_ram    in  1  SRAM serial data out
// - mosi_rom    out 1  ROM serial data in
// - cs_rom_n    out 1  ROM chip select, active low
// - hold_rom_n  out 1  ROM hold, active low (low = stream paused)
// - mosi_ram    out 1  SRAM serial data in
// - cs_ram_n    out 1  SRAM chip select, active low
// BEHAVIOUR
// - Registers: state[2:0], accumulator[23:0], ptr[23:0], ir[7:0], carry C, bit counter cnt[4:0].
// - Outputs are decoded from registers (Moore); reset does state=0, accumulator=ptr=0, C=0, cnt=0.
// - Idle/reset output values: cs_rom_n=1, hold_rom_n=1, mosi_rom=0, cs_ram_n=1, mosi_ram=0.
// - hold_rom_n=1 in states 0-3 and 0 in states 4-7. cs_rom_n=1 only in state 0.
// - States:
//   - 0 SEL: one cycle, cs_rom_n=1 -> 1.
//   - 1 CMD: 8 cycles, mosi_rom = 0x03 MSB first (0,0,0,0,0,0,1,1) -> 2.
//   - 2 ADDR: 24 cycles, mosi_rom=accumulator[0]; accumulator rotates right 1 bit/cycle, so it is restored
//     after 24 cycles; address is sent LSB first -> 3.
//   - 3 FETCH: 8 cycles, ir <= {ir[6:0],miso_rom} (MSB first); mosi_rom=0 -> 4.
//   - 4 EXEC: one cycle, ROM paused, executes ir:
//     - 0x0 NOP.
//     - 0x1n LDI: accumulator <= {accumulator[19:0],n}.
//     - 0x2n ADDI: {C,accumulator} <= accumulator+n (24-bit, C=carry out).
//     - 0x3n SUBI: accumulator <= accumulator-n, C=borrow.
//     - 0x4- CLR: accumulator=0, C=0.
//     - 0x5- XCH: swap accumulator and ptr.
//     - 0x6- JMP: -> state 0 (new READ at accumulator).
//     - 0x7- JC: if C -> state 0, else continue.
//     - 0x8- LD and 0x9- ST: -> state 5.
//     - 0xA-0xF: NOP.
//     - Low nibble is ignored where shown '-'.
//     - Non-jump and non-RAM instructions -> state 3, so the next ROM byte streams in.
//   - 5 RSEL: one cycle, cs_ram_n=1 -> 6.
//   - 6 RCMDADDR: 32 cycles, cs_ram_n=0.
//     - First 8 cycles: mosi_ram = 0x03 (LD) or 0x02 (ST), MSB first.
//     - Next 24 cycles: mosi_ram=ptr[0]; ptr rotates right and is restored at the end -> 7.
//   - 7 RDATA: 8 cycles, cs_ram_n=0.
//     - LD: accumulator <= {accumulator[23:8], shift-in of miso_ram MSB first}.
//     - ST: mosi_ram = accumulator[7:0] MSB first.
//     - Then cs_ram_n returns to 1 -> state 3.
// - cs_ram_n=1 in every state except 6 and 7.
// - cnt counts cycles within multi-cycle states and is cleared on every state change.
// - Post-reset sequence: the first cycle after rst falls is state 0. A complete READ follows:
//   - 1 cycle cs_rom_n=1.
//   - 8 cmd cycles, 24 addr cycles, 8 data cycles, all with cs_rom_n=0 and hold_rom_n=1.
//   - Then hold_rom_n=0.
// - Every entry into state 0 (reset or taken jump) produces that same 41-cycle sequence, then hold_rom_n=0.
// - rst asserted in any state (mid SPI transfer included) overrides everything: on the next edge state=0,
//   all outputs go to idle values, any RAM transfer is aborted (cs_ram_n=1) and accumulator=0.
// - Arithmetic wraps modulo 2^24.
// TESTING
// - Reset 1 cycle -> cs_rom_n=1 for 1 cycle, mosi_rom 00000011, 24x0, 8 data cycles with hold_rom_n=1,
//   then hold_rom_n=0.
// - ROM bytes 0x11,0x12,0x13,0x60 -> accumulator=0x000123, then READ with mosi_rom=accumulator[0]
//   rotating (address bits 1,1,0,0,0,1,0,0,1,0...).
// - ROM: CLR, LDI F x6, ADDI 1, JC -> accumulator=0, C=1, jump taken, READ at address 0.
//   Same program with ADDI 0 -> no jump, ROM stream continues.
// - ROM: LDI 5, XCH, LDI A, ST -> SRAM sees 0x02, ptr=5 LSB first, data 0x0A. A later LD (model returns 0x5C)
//   -> accumulator[7:0]=0x5C.
// - During a ST data phase and during a ROM ADDR phase, assert rst -> next cycle state 0, cs_ram_n=1,
//   cs_rom_n=1, then a fresh READ at address 0.

Source files
------------

// File: rtl/cpu_if.sv
// Serial memory bus of the bit-serial CPU: SPI ROM (instruction stream) and SPI SRAM (data).
// Both devices share the CPU clock as SCK, so only data/select/hold lines are grouped here.
interface cpu_if;
   logic miso_rom;
   logic miso_ram;
   logic mosi_rom;
   logic cs_rom_n;
   logic hold_rom_n;
   logic mosi_ram;
   logic cs_ram_n;

   modport master (
      input  miso_rom, miso_ram,
      output mosi_rom, cs_rom_n, hold_rom_n, mosi_ram, cs_ram_n
   );

   modport slave (
      output miso_rom, miso_ram,
      input  mosi_rom, cs_rom_n, hold_rom_n, mosi_ram, cs_ram_n
   );
endinterface

// File: rtl/cpu.sv
// Bit-serial accumulator CPU: streams instructions from an SPI ROM (paused with HOLD while
// executing) and loads/stores bytes in an SPI SRAM. All outputs are decoded from registers.
module cpu (
   input  logic  clk,
   input  logic  rst,
   cpu_if.master spi
);

   typedef enum logic [2:0] {
      S_SEL      = 3'd0,
      S_CMD      = 3'd1,
      S_ADDR     = 3'd2,
      S_FETCH    = 3'd3,
      S_EXEC     = 3'd4,
      S_RSEL     = 3'd5,
      S_RCMDADDR = 3'd6,
      S_RDATA    = 3'd7
   } state_t;

   localparam logic [7:0] SPI_READ = 8'h03;

   state_t      state_q, state_d;
   logic [23:0] acc_q, acc_d;
   logic [23:0] ptr_q, ptr_d;
   logic [7:0]  ir_q, ir_d;
   logic        c_q, c_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [7:0]  ram_cmd;
   logic        is_store;

   // ir[4] distinguishes ST (0x9-) from LD (0x8-): ST sends WRITE (0x02), LD sends READ (0x03)
   assign is_store = ir_q[4];
   assign ram_cmd  = {7'b0000001, ~is_store};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SEL;
         acc_q   <= '0;
         ptr_q   <= '0;
         ir_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ptr_q   <= ptr_d;
         ir_q    <= ir_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      ptr_d          = ptr_q;
      ir_d           = ir_q;
      c_d            = c_q;
      cnt_d          = cnt_q + 5'd1;
      spi.cs_rom_n   = 1'b0;
      spi.hold_rom_n = 1'b1;
      spi.mosi_rom   = 1'b0;
      spi.cs_ram_n   = 1'b1;
      spi.mosi_ram   = 1'b0;

      unique case (state_q)
         S_SEL: begin
            spi.cs_rom_n = 1'b1;
            state_d      = S_CMD;
         end
         S_CMD: begin
            spi.mosi_rom = SPI_READ[3'd7 - cnt_q[2:0]];
            if (cnt_q == 5'd7) state_d = S_ADDR;
         end
         S_ADDR: begin
            // Rotating the accumulator sends the address LSB first and restores it after 24 bits
            spi.mosi_rom = acc_q[0];
            acc_d        = {acc_q[0], acc_q[23:1]};
            if (cnt_q == 5'd23) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d = {ir_q[6:0], spi.miso_rom};
            if (cnt_q == 5'd7) state_d = S_EXEC;
         end
         S_EXEC: begin
            spi.hold_rom_n = 1'b0;
            state_d        = S_FETCH;
            case (ir_q[7:4])
               4'h1: acc_d = {acc_q[19:0], ir_q[3:0]};
               4'h2: {c_d, acc_d} = {1'b0, acc_q} + {21'd0, ir_q[3:0]};
               4'h3: {c_d, acc_d} = {1'b0, acc_q} - {21'd0, ir_q[3:0]};
               4'h4: begin
                  acc_d = '0;
                  c_d   = 1'b0;
               end
               4'h5: begin
                  acc_d = ptr_q;
                  ptr_d = acc_q;
               end
               4'h6: state_d = S_SEL;
               4'h7: if (c_q) state_d = S_SEL;
               4'h8, 4'h9: state_d = S_RSEL;
               default: ;
            endcase
         end
         S_RSEL: begin
            spi.hold_rom_n = 1'b0;
            state_d        = S_RCMDADDR;
         end
         S_RCMDADDR: begin
            spi.hold_rom_n = 1'b0;
            spi.cs_ram_n   = 1'b0;
            if (cnt_q < 5'd8) begin
               spi.mosi_ram = ram_cmd[3'd7 - cnt_q[2:0]];
            end else begin
               spi.mosi_ram = ptr_q[0];
               ptr_d        = {ptr_q[0], ptr_q[23:1]};
            end
            if (cnt_q == 5'd31) state_d = S_RDATA;
         end
         S_RDATA: begin
            spi.hold_rom_n = 1'b0;
            spi.cs_ram_n   = 1'b0;
            if (is_store) spi.mosi_ram = acc_q[3'd7 - cnt_q[2:0]];
            else          acc_d[7:0]   = {acc_q[6:0], spi.miso_ram};
            if (cnt_q == 5'd7) state_d = S_FETCH;
         end
         default: state_d = S_SEL;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu with behavioural SPI ROM and SPI SRAM models that log each transfer.
module tb_cpu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   cpu_if bus ();

   cpu dut (.clk(clk), .rst(rst), .spi(bus));

   always #5 clk = ~clk;

   int tests = 0;
   int failures = 0;

   // SPI ROM model: READ command, 24-bit address LSB first, then a sequential byte stream
   logic [7:0]  rom [256];
   int          rom_bits = 0;
   int          rom_dbit = 0;
   int          rom_reads = 0;
   logic [7:0]  rom_cmd_sh = '0;
   logic [23:0] rom_addr_sh = '0;
   logic [23:0] rom_ptr = '0;
   logic [7:0]  rom_last_cmd = '0;
   logic [23:0] rom_last_addr = '0;

   always @(posedge clk) begin
      if (bus.cs_rom_n !== 1'b0) begin
         rom_bits = 0;
         rom_dbit = 0;
      end else if (bus.hold_rom_n === 1'b1) begin
         if (rom_bits < 8) begin
            rom_cmd_sh = {rom_cmd_sh[6:0], bus.mosi_rom};
            rom_bits++;
         end else if (rom_bits < 32) begin
            rom_addr_sh = {bus.mosi_rom, rom_addr_sh[23:1]};
            rom_bits++;
            if (rom_bits == 32) begin
               rom_last_cmd  = rom_cmd_sh;
               rom_last_addr = rom_addr_sh;
               rom_ptr       = rom_addr_sh;
               rom_dbit      = 0;
               rom_reads++;
            end
         end else begin
            rom_dbit++;
            if (rom_dbit == 8) begin
               rom_dbit = 0;
               rom_ptr  = rom_ptr + 24'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] b;
      b = rom[rom_ptr[7:0]];
      bus.miso_rom = (rom_bits == 32) ? b[3'(7 - rom_dbit)] : 1'b0;
   end

   // SPI SRAM model: reads always return RAM_RD_VAL, writes are logged
   localparam logic [7:0] RAM_RD_VAL = 8'h5C;
   int          ram_bits = 0;
   int          ram_writes = 0;
   int          ram_reads = 0;
   logic [7:0]  ram_cmd_sh = '0;
   logic [23:0] ram_addr_sh = '0;
   logic [7:0]  ram_data_sh = '0;
   logic [7:0]  ram_last_cmd = '0;
   logic [23:0] ram_last_addr = '0;
   logic [7:0]  ram_last_data = '0;

   always @(posedge clk) begin
      if (bus.cs_ram_n !== 1'b0) begin
         ram_bits = 0;
      end else begin
         if (ram_bits < 8)       ram_cmd_sh  = {ram_cmd_sh[6:0], bus.mosi_ram};
         else if (ram_bits < 32) ram_addr_sh = {bus.mosi_ram, ram_addr_sh[23:1]};
         else if (ram_bits < 40) ram_data_sh = {ram_data_sh[6:0], bus.mosi_ram};
         ram_bits++;
         if (ram_bits == 40) begin
            ram_last_cmd  = ram_cmd_sh;
            ram_last_addr = ram_addr_sh;
            if (ram_cmd_sh == 8'h02) begin
               ram_last_data = ram_data_sh;
               ram_writes++;
            end else begin
               ram_reads++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] v;
      v = RAM_RD_VAL;
      bus.miso_ram = (ram_bits >= 32 && ram_bits < 40 && ram_cmd_sh == 8'h03)
                     ? v[3'(39 - ram_bits)] : 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic clear_rom();
      foreach (rom[i]) rom[i] = 8'h00;
   endtask

   task automatic wait_rom_read(input string tag, input logic [23:0] exp_addr);
      int start;
      int n;
      start = rom_reads;
      n = 0;
      while (rom_reads == start && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 32'(rom_reads != start), 32'd1);
      check({tag, "_cmd"}, 32'(rom_last_cmd), 32'h03);
      check({tag, "_addr"}, 32'(rom_last_addr), 32'(exp_addr));
   endtask

   task automatic idle_outputs(input string tag);
      check(tag, 32'({bus.cs_rom_n, bus.hold_rom_n, bus.mosi_rom, bus.cs_ram_n, bus.mosi_ram}),
            32'(5'b11010));
   endtask

   initial begin
      logic [7:0] cmd;
      logic [4:0] exp;
      int start;
      int n;
      cmd = 8'h03;

      // Reset waveform: SEL, READ command, zero address, 8 fetch cycles, then HOLD
      clear_rom();
      do_reset();
      for (int k = 0; k < 42; k++) begin
         if (k == 0)       exp = 5'b11010;
         else if (k <= 8)  exp = {1'b0, 1'b1, cmd[8 - k], 1'b1, 1'b0};
         else if (k <= 40) exp = 5'b01010;
         else              exp = 5'b00010;
         check($sformatf("reset_seq_c%0d", k),
               32'({bus.cs_rom_n, bus.hold_rom_n, bus.mosi_rom, bus.cs_ram_n, bus.mosi_ram}),
               32'(exp));
         tick();
      end

      // LDI 1,2,3 then JMP -> READ at 0x000123
      clear_rom();
      rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h13; rom[3] = 8'h60;
      do_reset();
      wait_rom_read("ldi_init", 24'h000000);
      wait_rom_read("ldi_jmp", 24'h000123);

      // Carry out of 0xFFFFFF + 1 makes JC jump to 0
      clear_rom();
      rom[0] = 8'h40;
      for (int i = 1; i <= 6; i++) rom[i] = 8'h1F;
      rom[7] = 8'h21; rom[8] = 8'h70; rom[9] = 8'h17; rom[10] = 8'h60;
      do_reset();
      wait_rom_read("jc_taken_init", 24'h000000);
      wait_rom_read("jc_taken", 24'h000000);

      // ADDI 0 leaves C clear: JC falls through, LDI 7 then JMP -> 0xFFFFF7
      rom[7] = 8'h20;
      do_reset();
      wait_rom_read("jc_not_init", 24'h000000);
      wait_rom_read("jc_not_taken", 24'hFFFFF7);

      // 2 - 3 wraps to 0xFFFFFF with borrow, JC taken
      clear_rom();
      rom[0] = 8'h40; rom[1] = 8'h12; rom[2] = 8'h33; rom[3] = 8'h70;
      rom[4] = 8'h17; rom[5] = 8'h60;
      do_reset();
      wait_rom_read("subi_init", 24'h000000);
      wait_rom_read("subi_borrow", 24'hFFFFFF);

      // LDI 5, XCH, LDI A, ST, LD, JMP
      clear_rom();
      rom[0] = 8'h15; rom[1] = 8'h50; rom[2] = 8'h1A; rom[3] = 8'h90;
      rom[4] = 8'h80; rom[5] = 8'h60;
      do_reset();
      wait_rom_read("ram_init", 24'h000000);
      start = ram_writes;
      n = 0;
      while (ram_writes == start && n < 3000) begin tick(); n++; end
      check("st_seen", 32'(ram_writes != start), 32'd1);
      check("st_cmd", 32'(ram_last_cmd), 32'h02);
      check("st_addr", 32'(ram_last_addr), 32'h000005);
      check("st_data", 32'(ram_last_data), 32'h0A);
      start = ram_reads;
      n = 0;
      while (ram_reads == start && n < 3000) begin tick(); n++; end
      check("ld_seen", 32'(ram_reads != start), 32'd1);
      check("ld_cmd", 32'(ram_last_cmd), 32'h03);
      check("ld_addr", 32'(ram_last_addr), 32'h000005);
      wait_rom_read("ld_jmp", 24'h00005C);

      // Reset in the middle of the ST data phase aborts the RAM write
      do_reset();
      n = 0;
      while (ram_bits != 34 && n < 3000) begin tick(); n++; end
      check("st_phase_reached", 32'(ram_bits), 32'd34);
      start = ram_writes;
      rst = 1'b1;
      tick();
      idle_outputs("rst_in_st_idle");
      rst = 1'b0;
      wait_rom_read("rst_in_st_reread", 24'h000000);
      check("rst_in_st_no_write", 32'(ram_writes - start), 32'd0);

      // Reset in the middle of the ROM address phase of the jump to 0x123
      clear_rom();
      rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h13; rom[3] = 8'h60;
      do_reset();
      wait_rom_read("rst_in_addr_init", 24'h000000);
      n = 0;
      while (rom_bits != 20 && n < 3000) begin tick(); n++; end
      check("addr_phase_reached", 32'(rom_bits), 32'd20);
      rst = 1'b1;
      tick();
      idle_outputs("rst_in_addr_idle");
      rst = 1'b0;
      wait_rom_read("rst_in_addr_reread", 24'h000000);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
